// File: rtl/mispredict_recovery.sv
// Branch-mispredict recovery sequencer: flush, ROB walk-back (rename-map restore and preg free), tail rollback, fetch redirect.
// Latency: FLUSH the cycle after mispredict_i, then K walk cycles and one REDIRECT cycle, where K = entries younger than the branch.
// Backpressure: none; busy_o stalls rename/dispatch/issue, and mispredict_i is ignored while busy.
module mispredict_recovery #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_W     = 4,
    parameter int PREG_W    = 7,
    parameter int AREG_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mispredict_i,
    input  logic [31:0]       target_pc_i,
    input  logic [ROB_W-1:0]  recover_tag_i,
    input  logic [ROB_W-1:0]  rob_tail_i,
    output logic [ROB_W-1:0]  walk_idx_o,
    input  logic              walk_rd_used_i,
    input  logic [AREG_W-1:0] walk_ard_i,
    input  logic [PREG_W-1:0] walk_prd_i,
    input  logic [PREG_W-1:0] walk_old_prd_i,
    output logic              flush_o,
    output logic              busy_o,
    output logic              map_restore_valid_o,
    output logic [AREG_W-1:0] map_restore_areg_o,
    output logic [PREG_W-1:0] map_restore_preg_o,
    output logic              free_valid_o,
    output logic [PREG_W-1:0] free_preg_o,
    output logic              rob_set_tail_valid_o,
    output logic [ROB_W-1:0]  rob_set_tail_o,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, WALK, REDIRECT} state_t;

    localparam logic [ROB_W-1:0] ONE = ROB_W'(1);

    state_t            state;
    logic [31:0]       tgt_q;
    logic [ROB_W-1:0]  tag_q;
    logic [ROB_W-1:0]  ptr_q;
    logic [ROB_W-1:0]  cnt_q;
    logic              walk_hit;

    // Unsigned ROB_W-bit arithmetic provides the modulo-ROB_DEPTH wrap for ptr, cnt and tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            tgt_q                <= '0;
            tag_q                <= '0;
            ptr_q                <= '0;
            cnt_q                <= '0;
            flush_o              <= 1'b0;
            busy_o               <= 1'b0;
            rob_set_tail_valid_o <= 1'b0;
            rob_set_tail_o       <= '0;
            redirect_valid_o     <= 1'b0;
            redirect_pc_o        <= '0;
        end else begin
            flush_o              <= 1'b0;
            rob_set_tail_valid_o <= 1'b0;
            rob_set_tail_o       <= '0;
            redirect_valid_o     <= 1'b0;
            redirect_pc_o        <= '0;
            case (state)
                IDLE: begin
                    if (mispredict_i) begin
                        tgt_q   <= target_pc_i;
                        tag_q   <= recover_tag_i;
                        ptr_q   <= rob_tail_i - ONE;
                        cnt_q   <= rob_tail_i - recover_tag_i - ONE;
                        flush_o <= 1'b1;
                        busy_o  <= 1'b1;
                        state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt_q != '0) begin
                        state <= WALK;
                    end else begin
                        redirect_valid_o     <= 1'b1;
                        redirect_pc_o        <= tgt_q;
                        rob_set_tail_valid_o <= 1'b1;
                        rob_set_tail_o       <= tag_q + ONE;
                        state                <= REDIRECT;
                    end
                end
                WALK: begin
                    ptr_q <= ptr_q - ONE;
                    cnt_q <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        redirect_valid_o     <= 1'b1;
                        redirect_pc_o        <= tgt_q;
                        rob_set_tail_valid_o <= 1'b1;
                        rob_set_tail_o       <= tag_q + ONE;
                        state                <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Restore/free strobes follow the same-cycle ROB read at walk_idx_o.
    assign walk_hit            = (state == WALK) && walk_rd_used_i;
    assign walk_idx_o          = ptr_q;
    assign map_restore_valid_o = walk_hit;
    assign map_restore_areg_o  = walk_hit ? walk_ard_i : '0;
    assign map_restore_preg_o  = walk_hit ? walk_old_prd_i : '0;
    assign free_valid_o        = walk_hit;
    assign free_preg_o         = walk_hit ? walk_prd_i : '0;

endmodule

// File: tb/tb_mispredict_recovery.sv
// Scoreboard bench for mispredict_recovery: per-cycle expected timeline from a ROB array model.
module tb_mispredict_recovery;

    localparam int ROB_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mispredict_i;
    logic [31:0] target_pc_i;
    logic [3:0]  recover_tag_i;
    logic [3:0]  rob_tail_i;
    logic [3:0]  walk_idx_o;
    logic        walk_rd_used_i;
    logic [4:0]  walk_ard_i;
    logic [6:0]  walk_prd_i;
    logic [6:0]  walk_old_prd_i;
    logic        flush_o, busy_o;
    logic        map_restore_valid_o;
    logic [4:0]  map_restore_areg_o;
    logic [6:0]  map_restore_preg_o;
    logic        free_valid_o;
    logic [6:0]  free_preg_o;
    logic        rob_set_tail_valid_o;
    logic [3:0]  rob_set_tail_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    mispredict_recovery dut (
        .clk(clk), .rst(rst), .mispredict_i(mispredict_i), .target_pc_i(target_pc_i),
        .recover_tag_i(recover_tag_i), .rob_tail_i(rob_tail_i), .walk_idx_o(walk_idx_o),
        .walk_rd_used_i(walk_rd_used_i), .walk_ard_i(walk_ard_i), .walk_prd_i(walk_prd_i),
        .walk_old_prd_i(walk_old_prd_i), .flush_o(flush_o), .busy_o(busy_o),
        .map_restore_valid_o(map_restore_valid_o), .map_restore_areg_o(map_restore_areg_o),
        .map_restore_preg_o(map_restore_preg_o), .free_valid_o(free_valid_o),
        .free_preg_o(free_preg_o), .rob_set_tail_valid_o(rob_set_tail_valid_o),
        .rob_set_tail_o(rob_set_tail_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    // ROB contents as seen by the walk read port.
    logic       rob_used [16];
    logic [4:0] rob_ard  [16];
    logic [6:0] rob_prd  [16];
    logic [6:0] rob_old  [16];

    assign walk_rd_used_i = rob_used[walk_idx_o];
    assign walk_ard_i     = rob_ard[walk_idx_o];
    assign walk_prd_i     = rob_prd[walk_idx_o];
    assign walk_old_prd_i = rob_old[walk_idx_o];

    typedef struct {
        logic        flush;
        logic        busy;
        logic [3:0]  idx;
        logic        mv;
        logic [4:0]  ma;
        logic [6:0]  mp;
        logic        fv;
        logic [6:0]  fp;
        logic        tv;
        logic [3:0]  tail;
        logic        rv;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [3:0] idle_idx;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp(input exp_t e);
        chk("ctrl{flush,busy,idx}", {flush_o, busy_o, walk_idx_o}, {e.flush, e.busy, e.idx});
        chk("map{v,areg,preg}", {map_restore_valid_o, map_restore_areg_o, map_restore_preg_o},
            {e.mv, e.ma, e.mp});
        chk("free{v,preg}", {free_valid_o, free_preg_o}, {e.fv, e.fp});
        chk("tail{v,tail}", {rob_set_tail_valid_o, rob_set_tail_o}, {e.tv, e.tail});
        chk("redirect{v,pc}", {redirect_valid_o, redirect_pc_o}, {e.rv, e.pc});
    endtask

    function automatic exp_t blank(input logic [3:0] idx);
        exp_t e;
        e = '{flush: 1'b0, busy: 1'b0, idx: idx, mv: 1'b0, ma: '0, mp: '0,
              fv: 1'b0, fp: '0, tv: 1'b0, tail: '0, rv: 1'b0, pc: '0};
        return e;
    endfunction

    // Monitor: a busy cycle consumes the next expected record; an idle cycle must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy at %0t: got busy=1 expected busy=0", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    cmp(mon_e);
                    if (mon_e.rv) idle_idx = mon_e.tail - 4'd1;
                end
            end else begin
                cmp(blank(idle_idx));
            end
        end
    end

    function automatic int younger(input int tail, input int tag);
        return (tail - tag - 1) & 15;
    endfunction

    // Expected timeline: flush, one record per younger entry (youngest first), redirect.
    task automatic push_expect(input int tail, input int tag, input logic [31:0] pc);
        exp_t e;
        int   k;
        int   idx;
        k = younger(tail, tag);
        e = blank(4'((tail - 1) & 15));
        e.flush = 1'b1;
        e.busy  = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < k; i++) begin
            idx    = (tail - 1 - i) & 15;
            e      = blank(4'(idx));
            e.busy = 1'b1;
            if (rob_used[idx]) begin
                e.mv = 1'b1; e.ma = rob_ard[idx]; e.mp = rob_old[idx];
                e.fv = 1'b1; e.fp = rob_prd[idx];
            end
            exp_q.push_back(e);
        end
        e      = blank(4'(tag));
        e.busy = 1'b1;
        e.tv   = 1'b1;
        e.tail = 4'((tag + 1) & 15);
        e.rv   = 1'b1;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    // Issue one mispredict; spur_j injects an ignored mispredict, rst_j resets mid-recovery.
    task automatic recover(input int tail, input int tag, input logic [31:0] pc,
                           input int spur_j, input int rst_j);
        int k;
        k = younger(tail, tag);
        push_expect(tail, tag, pc);
        mispredict_i  = 1'b1;
        rob_tail_i    = 4'(tail);
        recover_tag_i = 4'(tag);
        target_pc_i   = pc;
        @(posedge clk); #1;
        for (int j = 0; j < k + 2; j++) begin
            if (j == rst_j) begin
                mispredict_i = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                idle_idx = '0;
                return;
            end
            mispredict_i = (j == spur_j);
            if (j == spur_j) begin
                rob_tail_i    = 4'($urandom_range(0, 15));
                recover_tag_i = 4'($urandom_range(0, 15));
                target_pc_i   = $urandom;
            end
            @(posedge clk); #1;
        end
        mispredict_i = 1'b0;
    endtask

    task automatic clear_rob();
        for (int i = 0; i < 16; i++) begin
            rob_used[i] = 1'b0; rob_ard[i] = '0; rob_prd[i] = '0; rob_old[i] = '0;
        end
    endtask

    task automatic random_rob();
        for (int i = 0; i < 16; i++) begin
            rob_used[i] = 1'($urandom_range(0, 1));
            rob_ard[i]  = 5'($urandom_range(0, 31));
            rob_prd[i]  = 7'($urandom_range(0, 127));
            rob_old[i]  = 7'($urandom_range(0, 127));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int tail, tag, k, spur, rj;
        clear_rob();
        rst = 1'b1; mispredict_i = 1'b0; target_pc_i = '0;
        recover_tag_i = '0; rob_tail_i = '0; idle_idx = '0;
        idle(3);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Branch is youngest: flush then redirect straight away.
        recover(5, 4, 32'h100, -1, -1);
        idle(1);

        // Walk of three with a repeated areg.
        rob_used[7] = 1'b1; rob_prd[7] = 7'd40; rob_old[7] = 7'd10; rob_ard[7] = 5'd3;
        rob_used[6] = 1'b1; rob_prd[6] = 7'd41; rob_old[6] = 7'd11; rob_ard[6] = 5'd3;
        rob_used[5] = 1'b1; rob_prd[5] = 7'd42; rob_old[5] = 7'd12; rob_ard[5] = 5'd9;
        recover(8, 4, 32'h0000_2000, -1, -1);

        // Wrap-around with no rd writers, back-to-back with the previous recovery.
        clear_rob();
        rob_ard[0] = 5'd7; rob_prd[15] = 7'd99;
        recover(1, 14, 32'hdead_beef, -1, -1);
        idle(2);

        // Full ROB, with an ignored mispredict during the walk.
        random_rob();
        recover(3, 3, 32'h1234_5678, 6, -1);
        idle(1);

        // Reset mid-walk, then a normal recovery.
        random_rob();
        recover(10, 2, 32'h0bad_f00d, -1, 3);
        idle(2);
        recover(12, 9, 32'h0000_4444, -1, -1);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            random_rob();
            tail = $urandom_range(0, 15);
            tag  = $urandom_range(0, 15);
            k    = younger(tail, tag);
            spur = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, k + 1)) : -1;
            rj   = ($urandom_range(0, 7) == 0 && k >= 2) ? int'($urandom_range(1, k)) : -1;
            recover(tail, tag, $urandom, spur, rj);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
